minirisc_bus_arbiter: RTL and testbench
=======================================

MINIRISC_BUS_ARBITER -- requirements
Module: minirisc_bus_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-high.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- m0_bus_req  in  1  master 0 (CPU) bus request
- m0_bus_grant  out  1  master 0 grant
- m0_mst2slv_addr/_data  in  8  master 0 address / write data
- m0_mst2slv_wr/_rd  in  1  master 0 write / read strobe
- m1_bus_req  in  1  master 1 (DMA/debug) bus request
- m1_bus_grant  out  1  master 1 grant
- m1_mst2slv_addr/_data  in  8  master 1 address / write data
- m1_mst2slv_wr/_rd  in  1  master 1 write / read strobe
- s_mst2slv_addr/_data  out  8  slave-side address / write data
- s_mst2slv_wr/_rd  out  1  slave-side write / read strobe
- s_slv2mst_data  in  8  slave read data
- m_slv2mst_data  out  8  read data broadcast to both masters

Function
REQ-003 Grants SHALL come from registered state; states are IDLE, GNT0 and GNT1, and at most one grant SHALL be high in any cycle.
REQ-004 Transitions from IDLE SHALL be:
- req0 only -> GNT0
- req1 only -> GNT1
- both -> winner per REQ-007
- neither -> stay in IDLE
REQ-005 In GNTx the block SHALL stay while reqx=1 (no pre-emption, no timeout).
REQ-006 When reqx=0 in GNTx, the block SHALL hand over directly to the other master if it is requesting, otherwise go to IDLE.
REQ-007 Default arbitration SHALL be fixed priority: m0 wins simultaneous requests in IDLE.
REQ-008 Grant latency SHALL be:
- request seen in cycle n -> grant high from cycle n+1 (one edge)
- release seen in cycle n -> grant low from cycle n+1
REQ-009 Slave-side outputs SHALL be the granted master's addr/data/wr/rd, selected by the registered grant with no added register stage.
REQ-010 With no grant, all s_mst2slv_* outputs SHALL be 0.
REQ-011 m_slv2mst_data SHALL equal s_slv2mst_data combinationally.
REQ-012 A master's strobes SHALL be ignored (masked to 0 on the slave side) while that master is not granted.
REQ-013 On handover, the releasing master's signals SHALL NOT appear on the slave side in the first cycle of the new grant.
REQ-014 A request pulse lasting one cycle SHALL still produce exactly one grant cycle, followed by release.

Reset
REQ-015 While rst=1, state SHALL be IDLE, both grants 0 and all s_mst2slv_* 0, asynchronously and regardless of the clock.
REQ-016 A reset asserted mid-transfer SHALL drop the grant immediately.
REQ-017 After reset deassertion, arbitration SHALL restart from IDLE on the next clk edge.
REQ-018 The last-served pointer SHALL reset to m1, so m0 wins the first contention.

Configuration
REQ-019 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy:
- defined: a last-served register (1 bit) is kept; on contention in IDLE or at handover, the master not served last wins.
- undefined: fixed priority per REQ-007; no last-served register is synthesized.
REQ-020 All other behaviour SHALL be identical in both builds.

Verification
REQ-021 Scenario 1: reset, then req0=1 at cycle 2 -> m0_bus_grant=1 from cycle 3; s_mst2slv_addr follows m0 addr (e.g. 0x5A).
REQ-022 Scenario 2: simultaneous req0=req1=1 from IDLE ->
- fixed build: m0 granted
- round-robin build: m0 granted first (pointer reset to m1); after m0 releases with req1 held, m1 granted on the next edge with no IDLE cycle.
REQ-023 Scenario 3: m1 granted, m0 requests -> m1 keeps the grant until req1=0; m0 is granted the cycle after release.
REQ-024 Scenario 4: no grant, m1 drives wr=1, addr=0xFF -> s_mst2slv_wr=0 and s_mst2slv_addr=0x00.
REQ-025 Scenario 5: rst pulsed mid-grant (asynchronously, between edges) -> both grants and slave outputs go to 0 before the next edge.
REQ-026 Scenario 6: s_slv2mst_data=0x3C -> m_slv2mst_data=0x3C in the same cycle, in any state.
REQ-027 Every scenario SHALL check continuously that grants are never both high.

Source files
------------

// File: rtl/minirisc_bus_arbiter.sv
// Two-master bus arbiter: registered IDLE/GNT0/GNT1 grant state, combinational slave-side mux.
// Define ARB_ROUND_ROBIN_EN for last-served arbitration; default build is fixed priority (m0 wins).
module minirisc_bus_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_bus_req,
    output logic       m0_bus_grant,
    input  logic [7:0] m0_mst2slv_addr,
    input  logic [7:0] m0_mst2slv_data,
    input  logic       m0_mst2slv_wr,
    input  logic       m0_mst2slv_rd,
    input  logic       m1_bus_req,
    output logic       m1_bus_grant,
    input  logic [7:0] m1_mst2slv_addr,
    input  logic [7:0] m1_mst2slv_data,
    input  logic       m1_mst2slv_wr,
    input  logic       m1_mst2slv_rd,
    output logic [7:0] s_mst2slv_addr,
    output logic [7:0] s_mst2slv_data,
    output logic       s_mst2slv_wr,
    output logic       s_mst2slv_rd,
    input  logic [7:0] s_slv2mst_data,
    output logic [7:0] m_slv2mst_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   pick1;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_served;
    logic last_served_nxt;

    // Contention goes to whichever master was not served most recently.
    assign pick1 = ~last_served;

    always_comb begin
        last_served_nxt = last_served;
        if (state_nxt == GNT0)
            last_served_nxt = 1'b0;
        else if (state_nxt == GNT1)
            last_served_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_served <= 1'b1;
        else
            last_served <= last_served_nxt;
    end
`else
    assign pick1 = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        m0_bus_grant   = 1'b0;
        m1_bus_grant   = 1'b0;
        s_mst2slv_addr = 8'h00;
        s_mst2slv_data = 8'h00;
        s_mst2slv_wr   = 1'b0;
        s_mst2slv_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (m0_bus_req && m1_bus_req)
                    state_nxt = pick1 ? GNT1 : GNT0;
                else if (m0_bus_req)
                    state_nxt = GNT0;
                else if (m1_bus_req)
                    state_nxt = GNT1;
            end
            GNT0: begin
                if (!m0_bus_req)
                    state_nxt = m1_bus_req ? GNT1 : IDLE;
                m0_bus_grant   = 1'b1;
                s_mst2slv_addr = m0_mst2slv_addr;
                s_mst2slv_data = m0_mst2slv_data;
                s_mst2slv_wr   = m0_mst2slv_wr;
                s_mst2slv_rd   = m0_mst2slv_rd;
            end
            GNT1: begin
                if (!m1_bus_req)
                    state_nxt = m0_bus_req ? GNT0 : IDLE;
                m1_bus_grant   = 1'b1;
                s_mst2slv_addr = m1_mst2slv_addr;
                s_mst2slv_data = m1_mst2slv_data;
                s_mst2slv_wr   = m1_mst2slv_wr;
                s_mst2slv_rd   = m1_mst2slv_rd;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign m_slv2mst_data = s_slv2mst_data;

endmodule

// File: tb/tb_minirisc_bus_arbiter.sv
// Scoreboard bench for minirisc_bus_arbiter: owner-based reference model, directed scenarios then random traffic.
module tb_minirisc_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_bus_req, m1_bus_req;
    logic       m0_bus_grant, m1_bus_grant;
    logic [7:0] m0_mst2slv_addr, m0_mst2slv_data, m1_mst2slv_addr, m1_mst2slv_data;
    logic       m0_mst2slv_wr, m0_mst2slv_rd, m1_mst2slv_wr, m1_mst2slv_rd;
    logic [7:0] s_mst2slv_addr, s_mst2slv_data, s_slv2mst_data, m_slv2mst_data;
    logic       s_mst2slv_wr, s_mst2slv_rd;

    minirisc_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_bus_req(m0_bus_req), .m0_bus_grant(m0_bus_grant),
        .m0_mst2slv_addr(m0_mst2slv_addr), .m0_mst2slv_data(m0_mst2slv_data),
        .m0_mst2slv_wr(m0_mst2slv_wr), .m0_mst2slv_rd(m0_mst2slv_rd),
        .m1_bus_req(m1_bus_req), .m1_bus_grant(m1_bus_grant),
        .m1_mst2slv_addr(m1_mst2slv_addr), .m1_mst2slv_data(m1_mst2slv_data),
        .m1_mst2slv_wr(m1_mst2slv_wr), .m1_mst2slv_rd(m1_mst2slv_rd),
        .s_mst2slv_addr(s_mst2slv_addr), .s_mst2slv_data(s_mst2slv_data),
        .s_mst2slv_wr(s_mst2slv_wr), .s_mst2slv_rd(s_mst2slv_rd),
        .s_slv2mst_data(s_slv2mst_data), .m_slv2mst_data(m_slv2mst_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       req   [2];
        logic [7:0] addr  [2];
        logic [7:0] data  [2];
        logic       wr    [2];
        logic       rd    [2];
        logic [7:0] sdata;
    } stim_t;

    typedef struct {
        logic       g0, g1, wr, rd;
        logic [7:0] addr, data, mdata;
    } exp_t;

    exp_t  exp_q[$];
    stim_t cur, prev;
    int    owner;      // -1 none, else master index holding the bus
    int    last;       // master most recently granted
    int    checks = 0;
    int    errors = 0;
    bit    done   = 0;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Arbitration rules applied to the inputs held during the cycle that just ended.
    function automatic void model_edge(input stim_t s);
        int nxt;
        if (s.rst) begin
            owner = -1;
            last  = 1;
            return;
        end
        if (owner >= 0 && s.req[owner]) nxt = owner;
        else if (owner >= 0 && s.req[1-owner]) nxt = 1 - owner;
        else if (s.req[0] && s.req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
            nxt = 1 - last;
`else
            nxt = 0;
`endif
        end
        else if (s.req[0]) nxt = 0;
        else if (s.req[1]) nxt = 1;
        else nxt = -1;
        if (nxt >= 0) last = nxt;
        owner = nxt;
    endfunction

    function automatic exp_t expect_of(input stim_t s);
        exp_t e;
        int   o;
        o = s.rst ? -1 : owner;
        e.g0 = (o == 0);
        e.g1 = (o == 1);
        e.addr = (o >= 0) ? s.addr[o] : 8'h00;
        e.data = (o >= 0) ? s.data[o] : 8'h00;
        e.wr   = (o >= 0) ? s.wr[o]   : 1'b0;
        e.rd   = (o >= 0) ? s.rd[o]   : 1'b0;
        e.mdata = s.sdata;
        return e;
    endfunction

    task automatic step(input stim_t s);
        @(posedge clk);
        model_edge(prev);
        #2;
        rst = s.rst;
        m0_bus_req = s.req[0]; m1_bus_req = s.req[1];
        m0_mst2slv_addr = s.addr[0]; m0_mst2slv_data = s.data[0];
        m0_mst2slv_wr = s.wr[0]; m0_mst2slv_rd = s.rd[0];
        m1_mst2slv_addr = s.addr[1]; m1_mst2slv_data = s.data[1];
        m1_mst2slv_wr = s.wr[1]; m1_mst2slv_rd = s.rd[1];
        s_slv2mst_data = s.sdata;
        exp_q.push_back(expect_of(s));
        prev = s;
    endtask

    function automatic void randomize_payload();
        for (int i = 0; i < 2; i++) begin
            cur.addr[i] = 8'($urandom);
            cur.data[i] = 8'($urandom);
            cur.wr[i]   = 1'($urandom);
            cur.rd[i]   = 1'($urandom);
        end
        cur.sdata = 8'($urandom);
    endfunction

    task automatic run(input logic r, input logic q0, input logic q1, input int n);
        for (int i = 0; i < n; i++) begin
            randomize_payload();
            cur.rst = r; cur.req[0] = q0; cur.req[1] = q1;
            step(cur);
        end
    endtask

    // Monitor: compares every DUT output against the queued expectation, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("one_grant", {7'd0, m0_bus_grant & m1_bus_grant}, 8'h00);
                chk("m0_grant", {7'd0, m0_bus_grant}, {7'd0, e.g0});
                chk("m1_grant", {7'd0, m1_bus_grant}, {7'd0, e.g1});
                chk("s_addr", s_mst2slv_addr, e.addr);
                chk("s_data", s_mst2slv_data, e.data);
                chk("s_wr", {7'd0, s_mst2slv_wr}, {7'd0, e.wr});
                chk("s_rd", {7'd0, s_mst2slv_rd}, {7'd0, e.rd});
                chk("m_data", m_slv2mst_data, e.mdata);
            end
        end
    end

    initial begin
        rst = 1'b1;
        m0_bus_req = 0; m1_bus_req = 0;
        m0_mst2slv_addr = 0; m0_mst2slv_data = 0; m0_mst2slv_wr = 0; m0_mst2slv_rd = 0;
        m1_mst2slv_addr = 0; m1_mst2slv_data = 0; m1_mst2slv_wr = 0; m1_mst2slv_rd = 0;
        s_slv2mst_data = 0;
        owner = -1; last = 1;
        randomize_payload();
        cur.rst = 1; cur.req[0] = 0; cur.req[1] = 0;
        prev = cur;

        run(1, 0, 0, 2);
        // Scenario 1: m0 request with a fixed address
        run(0, 0, 0, 1);
        randomize_payload(); cur.rst = 0; cur.req[0] = 1; cur.req[1] = 0; cur.addr[0] = 8'h5A;
        step(cur); step(cur); step(cur);
        run(0, 0, 0, 2);
        // Scenario 4: ungranted m1 strobes must be masked
        randomize_payload(); cur.req[0] = 0; cur.req[1] = 0; cur.wr[1] = 1; cur.addr[1] = 8'hFF;
        step(cur); step(cur);
        // Scenario 2: simultaneous requests, then m0 releases with m1 held
        run(0, 1, 1, 3);
        run(0, 0, 1, 3);
        run(0, 0, 0, 1);
        // Scenario 3: m1 holds while m0 waits
        run(0, 0, 1, 2);
        run(0, 1, 1, 3);
        run(0, 1, 0, 2);
        run(0, 0, 0, 1);
        // Single-cycle request pulses
        run(0, 1, 0, 1);
        run(0, 0, 0, 3);
        run(0, 0, 1, 1);
        run(0, 0, 0, 2);
        // Scenario 5: reset asserted between edges mid-grant
        run(0, 1, 0, 3);
        run(1, 1, 0, 1);
        run(0, 1, 1, 3);
        // Scenario 6: read data passthrough in several states
        for (int i = 0; i < 4; i++) begin
            randomize_payload(); cur.rst = 0; cur.req[0] = (i == 1); cur.req[1] = (i >= 2);
            cur.sdata = 8'h3C;
            step(cur);
        end
        // Random traffic with sticky requests and rare resets
        for (int i = 0; i < 2000; i++) begin
            randomize_payload();
            cur.rst = ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++)
                if ($urandom_range(0, 3) == 0) cur.req[k] = 1'($urandom);
            step(cur);
        end
        run(0, 0, 0, 2);
        done = 1;
        @(posedge clk);
        @(posedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
